// File: rtl/cla_pkg.sv
// Shared helpers and types for the pipelined carry-look-ahead adder.
// The group-result struct describes the default group width.
package cla_pkg;

  localparam int CLA_DEF_GROUP = 8;

  typedef struct packed {
    logic                     cout;
    logic                     cMsb;
    logic [CLA_DEF_GROUP-1:0] sum;
  } grpRes_t;

  function automatic int ng(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-look-ahead group.
// It also exports the carry into its MSB for signed-overflow detection.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Each carry is a flat sum of products over generate/propagate terms, so bits do not ripple.
  always_comb begin
    logic term;
    logic chain;
    carry    = '0;
    term     = 1'b0;
    chain    = 1'b1;
    carry[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      term  = 1'b0;
      chain = 1'b1;
      for (int j = i; j >= 0; j--) begin
        term  = term | (gen[j] & chain);
        chain = chain & prop[j];
      end
      carry[i+1] = term | (chain & cin);
    end
  end

  assign sum   = prop ^ carry[GROUP-1:0];
  assign cout  = carry[GROUP];
  assign c_msb = carry[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-look-ahead adder/subtractor with valid/ready handshake.
// Rank 0 registers the operands; group k reads rank k and writes rank k+1.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NG = ng(WIDTH, GROUP);

  if (WIDTH % GROUP != 0) begin : gBadParams
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  logic [WIDTH-1:0] opA_q    [NG];
  logic [WIDTH-1:0] opB_q    [NG];
  logic [WIDTH-1:0] sum_q    [1:NG];
  logic [WIDTH-1:0] sum_d    [NG];
  logic [NG:0]      carry_q;
  logic [NG:0]      valid_q;
  logic             cMsb_q;

  logic [GROUP-1:0] grpSum   [NG];
  logic             grpCout  [NG];
  logic             grpCmsb  [NG];
  logic             stall;

  assign stall    = valid_q[NG] && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < NG; k++) begin : gStage
    cla_group #(.GROUP(GROUP)) uGroup (
      .a     (opA_q[k][k*GROUP +: GROUP]),
      .b     (opB_q[k][k*GROUP +: GROUP]),
      .cin   (carry_q[k]),
      .sum   (grpSum[k]),
      .cout  (grpCout[k]),
      .c_msb (grpCmsb[k])
    );
  end

  // Deskew: each rank carries the finished lower slices forward and drops its own slice in.
  always_comb begin
    for (int k = 0; k < NG; k++) begin
      sum_d[k] = '0;
    end
    sum_d[0][GROUP-1:0] = grpSum[0];
    for (int k = 1; k < NG; k++) begin
      sum_d[k]                   = sum_q[k];
      sum_d[k][k*GROUP +: GROUP] = grpSum[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      cMsb_q  <= 1'b0;
      for (int k = 0; k < NG; k++) begin
        opA_q[k]   <= '0;
        opB_q[k]   <= '0;
        sum_q[k+1] <= '0;
      end
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      opA_q[0]   <= in_a;
      opB_q[0]   <= in_sub ? ~in_b : in_b;
      carry_q[0] <= in_sub | in_cin;
      for (int k = 1; k < NG; k++) begin
        opA_q[k] <= opA_q[k-1];
        opB_q[k] <= opB_q[k-1];
      end
      for (int k = 0; k < NG; k++) begin
        valid_q[k+1] <= valid_q[k];
        carry_q[k+1] <= grpCout[k];
        sum_q[k+1]   <= sum_d[k];
      end
      cMsb_q <= grpCmsb[NG-1];
    end
  end

  assign out_valid = valid_q[NG];
  assign out_sum   = sum_q[NG];
  assign out_cout  = carry_q[NG];
  assign out_ovf   = cMsb_q ^ carry_q[NG];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench: directed vector table on the default 32/8 adder, plus
// streamed sequences against a reference model on 32/8, 64/16 and 8/8 instances.
module tb_cla_pipe_adder;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [65:0] res;
    int          t;
    int          st;
  } expRec_t;

  localparam int NG32 = 4;

  logic        clk;
  logic        rst_n;
  logic [63:0] tbA;
  logic [63:0] tbB;
  logic        tbCin;
  logic        tbSub;
  logic        tbValid;
  logic        tbOutReady;
  int          sel;

  logic        v32, v64, v8;
  logic        rdy32, rdy64, rdy8;
  logic        ov32, ov64, ov8;
  logic        co32, co64, co8;
  logic        of32, of64, of8;
  logic [31:0] s32;
  logic [63:0] s64;
  logic [7:0]  s8;

  logic        curOutValid, curInReady, curCout, curOvf;
  logic [63:0] curSum;

  int checksTotal  = 0;
  int checksPassed = 0;

  vec_t vecs [13];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign v32 = tbValid && (sel == 0);
  assign v64 = tbValid && (sel == 1);
  assign v8  = tbValid && (sel == 2);

  cla_pipe_adder #(.WIDTH(32), .GROUP(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
    .in_a(tbA[31:0]), .in_b(tbB[31:0]), .in_cin(tbCin), .in_sub(tbSub),
    .out_valid(ov32), .out_ready(tbOutReady), .out_sum(s32),
    .out_cout(co32), .out_ovf(of32)
  );

  cla_pipe_adder #(.WIDTH(64), .GROUP(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64),
    .in_a(tbA), .in_b(tbB), .in_cin(tbCin), .in_sub(tbSub),
    .out_valid(ov64), .out_ready(tbOutReady), .out_sum(s64),
    .out_cout(co64), .out_ovf(of64)
  );

  cla_pipe_adder #(.WIDTH(8), .GROUP(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
    .in_a(tbA[7:0]), .in_b(tbB[7:0]), .in_cin(tbCin), .in_sub(tbSub),
    .out_valid(ov8), .out_ready(tbOutReady), .out_sum(s8),
    .out_cout(co8), .out_ovf(of8)
  );

  // Route the selected instance onto common observation signals.
  always_comb begin
    curOutValid = ov32;
    curInReady  = rdy32;
    curSum      = {32'd0, s32};
    curCout     = co32;
    curOvf      = of32;
    case (sel)
      1: begin
        curOutValid = ov64; curInReady = rdy64; curSum = s64;
        curCout = co64; curOvf = of64;
      end
      2: begin
        curOutValid = ov8; curInReady = rdy8; curSum = {56'd0, s8};
        curCout = co8; curOvf = of8;
      end
      default: ;
    endcase
  end

  function automatic int widthOf(input int s);
    return (s == 1) ? 64 : (s == 2) ? 8 : 32;
  endfunction

  function automatic int ngOf(input int s);
    return (s == 2) ? 1 : 4;
  endfunction

  // Reference: plain wide addition, overflow from operand/result sign bits.
  function automatic logic [65:0] refAdd(input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sub, input int w);
    logic [64:0] mask, aa, bb, full;
    logic        cout, ovf;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = {1'b0, (sub ? ~b : b)} & mask;
    full = aa + bb + {64'd0, (sub | cin)};
    cout = full[w];
    ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return {ovf, cout, full[63:0] & mask[63:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One isolated operation on the 32-bit adder; checks it is absent one cycle early and correct on time.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    sel        = 0;
    tbOutReady = 1'b1;
    tbA        = {32'd0, v.a};
    tbB        = {32'd0, v.b};
    tbCin      = v.cin;
    tbSub      = v.sub;
    tbValid    = 1'b1;
    @(negedge clk);
    tbValid = 1'b0;
    repeat (NG32 - 1) @(negedge clk);
    checkOutput({v.name, " early"}, {63'd0, ov32}, 64'd0);
    @(negedge clk);
    checkOutput({v.name, " valid"}, {63'd0, ov32}, 64'd1);
    checkOutput({v.name, " sum"},   {32'd0, s32},  {32'd0, v.sum});
    checkOutput({v.name, " cout"},  {63'd0, co32}, {63'd0, v.cout});
    checkOutput({v.name, " ovf"},   {63'd0, of32}, {63'd0, v.ovf});
  endtask

  // Cycle-stepped stream against a queue model that predicts out_valid, in_ready and results.
  task automatic runStream(input int selIn, input int nOps, input bit scripted);
    expRec_t     q[$];
    expRec_t     rec;
    int          sent, got, cyc, stalls, w, ngv, limit;
    bit          modelValid, expReady, accepted;
    sel      = selIn;
    w        = widthOf(selIn);
    ngv      = ngOf(selIn);
    sent     = 0;
    got      = 0;
    cyc      = 0;
    stalls   = 0;
    limit    = nOps * 8 + 100;
    accepted = 1'b0;
    tbValid  = 1'b0;
    while (got < nOps && cyc < limit) begin
      @(negedge clk);
      if (accepted) tbValid = 1'b0;
      accepted = 1'b0;
      if (scripted) tbOutReady = !(cyc >= 6 && cyc < 9);
      else          tbOutReady = ($urandom_range(0, 3) != 0);
      if (!tbValid && sent < nOps && (scripted || $urandom_range(0, 3) != 0)) begin
        tbA     = {$urandom, $urandom};
        tbB     = {$urandom, $urandom};
        tbCin   = 1'($urandom_range(0, 1));
        tbSub   = 1'($urandom_range(0, 1));
        tbValid = 1'b1;
      end
      #1;
      modelValid = (q.size() > 0) && ((cyc - q[0].t - (stalls - q[0].st)) >= ngv);
      expReady   = !(modelValid && !tbOutReady);
      checkOutput("stream out_valid", {63'd0, curOutValid}, {63'd0, modelValid});
      checkOutput("stream in_ready",  {63'd0, curInReady},  {63'd0, expReady});
      if (modelValid) begin
        checkOutput("stream sum",  curSum,            q[0].res[63:0]);
        checkOutput("stream cout", {63'd0, curCout},  {63'd0, q[0].res[64]});
        checkOutput("stream ovf",  {63'd0, curOvf},   {63'd0, q[0].res[65]});
        if (tbOutReady) begin
          void'(q.pop_front());
          got++;
        end
      end
      if (!expReady) stalls++;
      if (tbValid && curInReady) begin
        rec.res = refAdd(tbA, tbB, tbCin, tbSub, w);
        rec.t   = cyc + 1;
        rec.st  = stalls;
        q.push_back(rec);
        sent++;
        accepted = 1'b1;
      end
      cyc++;
    end
    if (got < nOps) checkOutput("stream timeout", 64'(got), 64'(nOps));
    @(negedge clk);
    tbValid    = 1'b0;
    tbOutReady = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{"add ff+1",      32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1]  = '{"wrap cin",      32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{"sub 5-7",       32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3]  = '{"sub min-1",     32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[4]  = '{"sub 5-7 cin",   32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[5]  = '{"sub min-1 cin", 32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[6]  = '{"add max+1",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[7]  = '{"add mixed",     32'h12345678, 32'h87654321, 1'b1, 1'b0, 32'h9999999A, 1'b0, 1'b0};
    vecs[8]  = '{"sub 0-0",       32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[9]  = '{"add min+min",   32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[10] = '{"sub max-(-1)",  32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};
    vecs[11] = '{"group carry",   32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0};
    vecs[12] = '{"add all ones",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};

    sel        = 0;
    tbA        = '0;
    tbB        = '0;
    tbCin      = 1'b0;
    tbSub      = 1'b0;
    tbValid    = 1'b0;
    tbOutReady = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset out_valid", {63'd0, ov32}, 64'd0);
    checkOutput("reset sum",       {32'd0, s32},  64'd0);
    checkOutput("reset cout",      {63'd0, co32}, 64'd0);
    checkOutput("reset ovf",       {63'd0, of32}, 64'd0);
    checkOutput("reset in_ready",  {63'd0, rdy32}, 64'd1);
    checkOutput("reset valid64",   {63'd0, ov64}, 64'd0);
    checkOutput("reset valid8",    {63'd0, ov8},  64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] backpressure stream");
    runStream(0, 10, 1'b1);

    $display("[TB] reset with operations in flight");
    @(negedge clk);
    sel        = 0;
    tbOutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tbA     = 64'(i + 1);
      tbB     = 64'h1;
      tbCin   = 1'b0;
      tbSub   = 1'b0;
      tbValid = 1'b1;
      @(negedge clk);
    end
    tbValid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("flush out_valid", {63'd0, ov32},  64'd0);
    checkOutput("flush sum",       {32'd0, s32},   64'd0);
    checkOutput("flush cout",      {63'd0, co32},  64'd0);
    checkOutput("flush ovf",       {63'd0, of32},  64'd0);
    checkOutput("flush in_ready",  {63'd0, rdy32}, 64'd1);
    repeat (6) begin
      @(negedge clk);
      checkOutput("flush no stale", {63'd0, ov32}, 64'd0);
    end
    applyStimulus(vecs[0]);

    $display("[TB] random stream 64/16");
    runStream(1, 10000, 1'b0);
    $display("[TB] random stream 8/8");
    runStream(2, 10000, 1'b0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not complete, passed %0d of %0d", checksPassed, checksTotal);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-look-ahead adder/subtractor for the datapath's wide-add slot. The operand is split into GROUP-bit look-ahead groups, with one register stage per group on the ripple path between groups. It accepts one operation per clock under a valid/ready handshake and returns sum, carry-out and signed overflow after a fixed latency. It is the successor to the fixed 32-bit, four-group combinational adder, adding add/subtract mode, pipelining and backpressure.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of GROUP (elaboration error otherwise).
- GROUP, 8, bits per look-ahead group; NG = WIDTH/GROUP (pipeline depth).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in, used in add mode only.
- in_sub  in  1  1 = A − B (B inverted, carry-in forced to 1, in_cin ignored); 0 = A + B + in_cin.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result bits.
- out_cout  out  1  carry out of MSB. In subtract mode this is the not-borrow flag.
- out_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Stage k (k = 0..NG−1) computes group k with a GROUP-bit CLA, using its registered carry-in.
- Stage k registers: the group-k sum slice, the group's carry-out, and the still-unused upper operand slices (skew).
- Earlier sum slices travel forward in deskew registers, so all slices of one operation exit together.
- Stage 0 carry-in is in_sub ? 1 : in_cin. B is inverted at entry when in_sub = 1.
- out_ovf is taken from the last group: carry into bit WIDTH−1 XOR out_cout.
- Each stage has a valid bit.
- Global stall: stall = out_valid && !out_ready. While stalled, every pipeline register holds, bubbles included.
- in_ready = !stall. Combinational, with no dependence on in_valid.
- A transfer when in_ready = 0 is not possible. Input held while in_ready = 0 is sampled only once in_ready rises.
- Arithmetic is modulo 2^WIDTH. Wrap example: 0xFFFFFFFF + 1 gives sum 0, cout 1, ovf 0.

## Timing
- Latency: a transfer accepted at edge t gives out_valid = 1 after edge t+NG, provided there are no stalls. Each stall cycle adds one cycle.
- Throughput: one operation per cycle while out_ready = 1.
- Operations exit in input order. No operation is dropped or duplicated.
- out_sum, out_cout and out_ovf are stable while out_valid && !out_ready.
- Reset (rst_n = 0 at an edge):
  - All valid bits clear, out_valid = 0.
  - out_sum = 0, out_cout = 0, out_ovf = 0.
  - in_ready = 1 from the first cycle after the reset edge.
- Reset mid-operation flushes all in-flight operations; none are output afterwards.
- Simultaneous accept and output in the same cycle is normal streaming and requires no special case.
- NG = 1 is legal: a single registered CLA with latency 1.

## Structure
- Package cla_pkg: localparam helper function ng(width, group). Also holds a typedef for the packed group result {cout, carry-into-MSB, sum[GROUP−1:0]}.
- Sub-module cla_group: combinational GROUP-bit look-ahead group.
  - Inputs a, b, cin.
  - Outputs sum, cout, c_msb (carry into the group MSB, used for overflow).
  - Instantiated NG times.
- Top level (cla_pipe_adder) contains the skew/deskew registers, the valid chain, the stall logic and the sub-mode entry inversion.

## Test plan
- Default params, add: a=0x0000_00FF, b=0x0000_0001, cin=0 → after 4 cycles, out_sum=0x0000_0100, cout=0, ovf=0.
- Wrap and full-chain carry: a=0xFFFF_FFFF, b=0, cin=1 → sum=0, cout=1, ovf=0.
- Subtract:
  - 5 − 7 → sum=0xFFFF_FFFE, cout=0, ovf=0.
  - 0x8000_0000 − 1 → sum=0x7FFF_FFFF, cout=1, ovf=1.
  - Both with in_cin=1, which must be ignored.
- Backpressure:
  - Stream 10 back-to-back operations with out_ready low for 3 cycles mid-stream.
  - in_ready must be low exactly during stalled cycles, output held stable.
  - All 10 results in order, each checked against a reference model.
- Reset mid-flight: drop rst_n for 1 cycle with 3 operations in flight → out_valid=0 and outputs=0 next cycle; no stale result ever appears; the next operation has latency 4.
- Parameter sweep: WIDTH=64, GROUP=16 and WIDTH=8, GROUP=8, each with 10k random add/sub operations under random out_ready → matches the reference model, latency NG when unstalled.
